// File: rtl/perf_pkg.sv
// perf_pkg: FSM state type and default sizes shared by the performance counter unit
package perf_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NUM_EVT_DEF = 4;
  localparam int CNT_W_DEF = 32;
endpackage

// File: rtl/perf_evt_counter.sv
// perf_evt_counter: one event counter with enable, sync clear (rst_i active-low wins) and sticky overflow; wraps, or saturates when PERF_CNT_SAT_EN is defined
module perf_evt_counter
  import perf_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         ovf_o
);
  logic [W-1:0] cnt_nxt;
`ifdef PERF_CNT_SAT_EN
  assign cnt_nxt = &cnt_o ? cnt_o : cnt_o + 1'b1;
`else
  assign cnt_nxt = cnt_o + 1'b1;
`endif
  always_ff @(posedge clk_i) begin
    if (!rst_i || clr_i) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (en_i) begin
      cnt_o <= cnt_nxt;
      ovf_o <= ovf_o | (&cnt_o);
    end
  end
endmodule

// File: rtl/perf_counter_unit.sv
// perf_counter_unit: IDLE/RUN/DONE measurement run with cycle counter, NUM_EVT event counters, registered readback (clk_i, rst_i active-low sync, start_i, clr_i, evt_i, limit_i, rd_sel_i -> rd_data_o, cycle_o, running_o, done_o, ovf_o); PERF_CNT_SAT_EN selects saturating event counters
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int NUM_EVT = NUM_EVT_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int SEL_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clr_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [CNT_W-1:0]   limit_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic [CNT_W-1:0]   cycle_o,
  output logic               running_o,
  output logic               done_o,
  output logic [NUM_EVT-1:0] ovf_o
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cyc, cyc_inc;
  logic [CNT_W-1:0] cnt [NUM_EVT];
  logic [CNT_W-1:0] pad [2**SEL_W];
  assign cyc_inc = cyc + 1'b1;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (start_i ? RUN : IDLE) :
                state == RUN ? ((limit_i != '0 && cyc_inc == limit_i) ? DONE : RUN) : DONE;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      cyc       <= '0;
      rd_data_o <= '0;
    end else begin
      rd_data_o <= pad[rd_sel_i];
      if (clr_i) begin
        state <= IDLE;
        cyc   <= '0;
      end else begin
        state <= state_nxt;
        if (state == RUN) cyc <= cyc_inc;
      end
    end
  end
  assign cycle_o   = cyc;
  assign running_o = state == RUN;
  assign done_o    = state == DONE;
  for (genvar k = 0; k < NUM_EVT; k++) begin : g_ch
    perf_evt_counter #(.W(CNT_W)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clr_i),
      .en_i  (state == RUN && evt_i[k]),
      .cnt_o (cnt[k]),
      .ovf_o (ovf_o[k])
    );
  end
  for (genvar k = 0; k < 2**SEL_W; k++) begin : g_pad
    if (k < NUM_EVT) begin : g_on
      assign pad[k] = cnt[k];
    end else begin : g_off
      assign pad[k] = '0;
    end
  end
endmodule

// File: tb/tb_perf_counter_unit.sv
// tb_perf_counter_unit: randomized and directed checks of perf_counter_unit against a behavioural run model
module tb_perf_counter_unit;
  localparam int NE = 5;
  localparam int CW = 8;
  localparam int SW = 3;
  localparam int MAXV = (1 << CW) - 1;
`ifdef PERF_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0, start = 1'b0, clr = 1'b0;
  logic [NE-1:0] evt = '0;
  logic [CW-1:0] limit = '0;
  logic [SW-1:0] sel = '0;
  logic [CW-1:0] rd_data, cycle;
  logic running, done;
  logic [NE-1:0] ovf;
  int n_cmp = 0, n_err = 0;
  int md = 0;
  int m_cyc = 0, m_rd = 0;
  int m_cnt [NE];
  logic [NE-1:0] m_ovf = '0;
  perf_counter_unit #(.NUM_EVT(NE), .CNT_W(CW), .SEL_W(SW)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .clr_i     (clr),
    .evt_i     (evt),
    .limit_i   (limit),
    .rd_sel_i  (sel),
    .rd_data_o (rd_data),
    .cycle_o   (cycle),
    .running_o (running),
    .done_o    (done),
    .ovf_o     (ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic zero_model();
    md = 0;
    m_cyc = 0;
    m_ovf = '0;
    for (int k = 0; k < NE; k++) m_cnt[k] = 0;
  endtask
  task automatic model();
    if (!rst) begin
      zero_model();
      m_rd = 0;
    end else begin
      m_rd = int'(sel) < NE ? m_cnt[sel] : 0;
      if (clr) zero_model();
      else if (md == 0) md = start ? 1 : 0;
      else if (md == 1) begin
        m_cyc = (m_cyc + 1) % (MAXV + 1);
        for (int k = 0; k < NE; k++)
          if (evt[k]) begin
            if (m_cnt[k] == MAXV) begin
              m_ovf[k] = 1'b1;
              m_cnt[k] = SAT ? MAXV : 0;
            end else m_cnt[k]++;
          end
        if (limit != 0 && m_cyc == int'(limit)) md = 2;
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("running", 64'(running), 64'(md == 1));
    chk("done", 64'(done), 64'(md == 2));
    chk("cycle", 64'(cycle), 64'(m_cyc));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    chk("rd_data", 64'(rd_data), 64'(m_rd));
  endtask
  initial begin
    zero_model();
    rst = 1'b0;
    step();
    step();
    chk("rst_cycle", 64'(cycle), 64'd0);
    chk("rst_rd", 64'(rd_data), 64'd0);
    rst = 1'b1;
    limit = 8'd64;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      evt = {3'b000, i % 4 == 0, 1'b1};
      step();
    end
    chk("lim_done", 64'(done), 64'd1);
    chk("lim_cycle", 64'(cycle), 64'd64);
    for (int i = 0; i < 6; i++) begin
      evt = NE'($urandom);
      start = i[0];
      step();
    end
    evt = '0;
    start = 1'b0;
    chk("done_hold", 64'(done), 64'd1);
    chk("done_cycle", 64'(cycle), 64'd64);
    sel = 3'd0; step(); chk("rd_ch0", 64'(rd_data), 64'd64);
    sel = 3'd1; step(); chk("rd_ch1", 64'(rd_data), 64'd16);
    sel = 3'd2; step(); chk("rd_ch2", 64'(rd_data), 64'd0);
    sel = 3'd3; step(); chk("rd_ch3", 64'(rd_data), 64'd0);
    sel = 3'd5; step(); chk("rd_sel5", 64'(rd_data), 64'd0);
    clr = 1'b1; step(); clr = 1'b0;
    evt = '1; step(); step();
    chk("idle_evt_ign", 64'(running), 64'd0);
    limit = 8'd0;
    evt = '0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    evt = '1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    evt = '0;
    chk("clr_running", 64'(running), 64'd0);
    chk("clr_ovf", 64'(ovf), 64'd0);
    chk("clr_cycle", 64'(cycle), 64'd0);
    start = 1'b1; step(); start = 1'b0;
    evt = 5'b00100;
    for (int i = 0; i < 300; i++) step();
    evt = '0;
    chk("wrap_ovf2", 64'(ovf[2]), 64'd1);
    sel = 3'd2; step();
    chk("wrap_ch2", 64'(rd_data), SAT ? 64'd255 : 64'd44);
    start = 1'b1;
    evt = 5'b00011;
    step(); step();
    rst = 1'b0; step();
    chk("mid_rst_run", 64'(running), 64'd0);
    chk("mid_rst_cycle", 64'(cycle), 64'd0);
    rst = 1'b1; step();
    chk("rerun", 64'(running), 64'd1);
    chk("rerun_cycle", 64'(cycle), 64'd0);
    step();
    chk("restart_cycle", 64'(cycle), 64'd1);
    for (int i = 0; i < 1500; i++) begin
      rst = $urandom_range(0, 99) != 0;
      clr = $urandom_range(0, 59) == 0;
      start = $urandom_range(0, 3) == 0;
      evt = NE'($urandom);
      sel = SW'($urandom);
      if ($urandom_range(0, 29) == 0) limit = CW'($urandom_range(0, 40));
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/perf_counter_unit.md
PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

Interface
REQ-001 The block SHALL have parameter NUM_EVT, default 4, meaning the number of independent event channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 32, meaning the width of every event counter, the cycle counter and limit_i (8..64).
REQ-003 The block SHALL have parameter SEL_W, default 2, meaning the width of rd_sel_i, with SEL_W = max(1, clog2(NUM_EVT)).
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  synchronous reset, active-low.
REQ-006 start_i  input  1  level request to begin a measurement run.
REQ-007 clr_i  input  1  synchronous clear of all counters, flags and state.
REQ-008 evt_i  input  NUM_EVT  per-channel event pulses; bit k counts toward channel k.
REQ-009 limit_i  input  CNT_W  run length in cycles; 0 means unlimited.
REQ-010 rd_sel_i  input  SEL_W  channel select for readback.
REQ-011 rd_data_o  output  CNT_W  registered value of the selected event counter.
REQ-012 cycle_o  output  CNT_W  current cycle counter.
REQ-013 running_o  output  1  high while in state RUN.
REQ-014 done_o  output  1  high while in state DONE.
REQ-015 ovf_o  output  NUM_EVT  sticky per-channel overflow flags.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 IDLE SHALL go to RUN on the edge where start_i=1; cycle and event counters are not updated on that edge.
REQ-018 In RUN, each edge SHALL increment the cycle counter by 1 and increment channel k by 1 where evt_i[k]=1.
REQ-019 In RUN with limit_i != 0, the edge on which the cycle counter becomes equal to limit_i SHALL move the FSM to DONE, and events on that edge SHALL be counted.
REQ-020 With limit_i = 0 the FSM SHALL stay in RUN until clr_i; the cycle counter wraps modulo 2^CNT_W.
REQ-021 start_i SHALL be ignored in RUN and DONE; evt_i SHALL be ignored in IDLE and DONE.
REQ-022 In DONE all counters SHALL hold and done_o SHALL stay 1 until clr_i or reset.
REQ-023 clr_i SHALL zero all counters and ovf_o and force IDLE, taking priority over start_i, evt_i and the limit transition on the same edge.
REQ-024 An event arriving on a counter at all-ones SHALL set ovf_o[k]; the counter's next value is given under Configuration.
REQ-025 rd_data_o SHALL equal counter[rd_sel_i] sampled on the previous edge (1-cycle latency); rd_sel_i >= NUM_EVT SHALL return 0.
REQ-026 A change of limit_i during RUN SHALL take effect on the next edge; if the new limit is already <= the cycle counter, the run continues until wrap-around equality.

Reset
REQ-027 When rst_i=0 at an edge, the state SHALL become IDLE, and all counters, rd_data_o, cycle_o, running_o, done_o and ovf_o SHALL become 0.
REQ-028 Reset asserted during RUN or DONE SHALL abandon the run with no further event counting; reset takes priority over clr_i.

Configuration
REQ-029 With macro PERF_CNT_SAT_EN defined, event counters SHALL saturate at all-ones on overflow.
REQ-030 Without PERF_CNT_SAT_EN, event counters SHALL wrap to 0 on overflow; ovf_o behaviour SHALL be identical in both builds.

Structure
REQ-031 Package perf_pkg SHALL hold the FSM state enum (IDLE/RUN/DONE) and the default constants for NUM_EVT and CNT_W.
REQ-032 A sub-module perf_evt_counter (one CNT_W counter with enable, clear and sticky overflow, macro-selected wrap or saturate) SHALL be instantiated NUM_EVT times.

Verification
REQ-033 Reset, start_i=1, limit_i=64, evt_i[0] held 1, evt_i[1] pulsed every 4th cycle -> done_o=1 after 64 RUN edges; cycle_o=64; ch0=64; ch1=16.
REQ-034 CNT_W=8, evt_i[2] held 1 for 300 cycles, limit_i=0 -> ovf_o[2]=1; ch2=255 with PERF_CNT_SAT_EN, 44 without.
REQ-035 clr_i and evt_i=all-ones on the same edge in RUN -> all counters 0; state IDLE; ovf_o=0.
REQ-036 rd_sel_i stepped 0,1,2,3,5 in DONE -> rd_data_o presents each channel value one cycle later; the select of 5 reads 0.
REQ-037 rst_i=0 for one edge mid-run with start_i still 1 -> all outputs 0 on that edge; RUN re-entered on the next edge; counting restarts from 0.
REQ-038 Events asserted in IDLE and in DONE, and start_i pulsed in DONE -> no counter changes and no state change.
